// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - synchronous modulo-N up/down counter digit with load, saturate and event flags
module mod_n_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = 0
) (
    input  logic             input_CLK,
    input  logic             input_RST_N,
    input  logic             input_ENA,
    input  logic             input_UP,
    input  logic             input_LOAD,
    input  logic [WIDTH-1:0] input_D,
    input  logic             input_CLR_FLAG,
    output logic [WIDTH-1:0] output_Y,
    output logic             output_TC,
    output logic             output_OVF,
    output logic             output_UNF,
    output logic             output_STICKY
);

    // Top of range held in WIDTH bits so MODULUS == 2**WIDTH never needs an extra bit.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             sticky_q, sticky_d;
    logic             at_max, at_zero;

    assign at_max  = (y_q == MAX_VAL);
    assign at_zero = (y_q == '0);

    always_comb begin
        y_d   = y_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (input_LOAD) begin
            y_d = (input_D > MAX_VAL) ? MAX_VAL : input_D;
        end else if (input_ENA) begin
            if (input_UP) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    y_d   = (SATURATE != 0) ? y_q : '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    unf_d = 1'b1;
                    y_d   = (SATURATE != 0) ? y_q : MAX_VAL;
                end else begin
                    y_d = y_q - 1'b1;
                end
            end
        end
        // A new event beats a simultaneous clear request.
        if (ovf_d || unf_d) begin
            sticky_d = 1'b1;
        end else if (input_CLR_FLAG) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge input_CLK) begin
        if (!input_RST_N) begin
            y_q      <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    // Combinational so a cascaded digit advances on the same edge as this digit wraps.
    assign output_TC     = input_ENA & ~input_LOAD & (input_UP ? at_max : at_zero);
    assign output_Y      = y_q;
    assign output_OVF    = ovf_q;
    assign output_UNF    = unf_q;
    assign output_STICKY = sticky_q;

endmodule
